// File: rtl/mcpu_io_pkg.sv
// Shared constants for the mcpu I/O responder: region select, register offsets,
// KSTAT bit layout and a helper that packs the KSTAT word.
package mcpu_io_pkg;

  localparam logic [1:0] IO_REGION = 2'b11;

  localparam logic [2:0] IO_KSTAT = 3'd0;
  localparam logic [2:0] IO_KDATA = 3'd1;
  localparam logic [2:0] IO_FRAME = 3'd2;
  localparam logic [2:0] IO_TIMER = 3'd3;
  localparam logic [2:0] IO_TSTAT = 3'd4;

  localparam int unsigned KSTAT_NE      = 0;
  localparam int unsigned KSTAT_FULL    = 1;
  localparam int unsigned KSTAT_OVF     = 2;
  localparam int unsigned KSTAT_CNT_LSB = 4;
  localparam int unsigned KSTAT_CNT_W   = 5;

  // Build the 16-bit KSTAT read value; unused bits are zero.
  function automatic logic [15:0] kstat_pack(input logic ne, input logic full,
                                             input logic ovf,
                                             input logic [KSTAT_CNT_W-1:0] cnt);
    logic [15:0] w;
    w = '0;
    w[KSTAT_NE]   = ne;
    w[KSTAT_FULL] = full;
    w[KSTAT_OVF]  = ovf;
    w[KSTAT_CNT_LSB +: KSTAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mcpu_io_fifo.sv
// Keycode FIFO: power-of-two depth, combinational head, flush beats push/pop.
// A pop on an empty FIFO is ignored; a push on a full FIFO lands only if a pop
// frees a slot in the same cycle.
module mcpu_io_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mcpu_io_resp.sv
// Memory-mapped I/O responder for the 0xC000-0xFFFF region of the mcpu bus:
// keycode FIFO, vsync frame counter and (with MCPU_IO_TIMER_EN) a prescaled
// down-counter timer. rdata is combinational to match the top-level bus mux.
module mcpu_io_resp
  import mcpu_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMER_PRESCALE = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [7:0]            keycode,
  input  logic                  vsync,
  output logic                  irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel, rd_hit, wr_hit;
  logic [2:0]    off;
  logic [7:0]    kprev_q;
  logic          kbd_push, kpop, kflush;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          ovf_q, ovf_d;
  logic [15:0]   frame_q, frame_d;
  logic          vsync_q, vsync_q2;
  logic          timer_exp;
  logic [15:0]   timer_rd;

  assign sel    = (addr[15:14] == IO_REGION);
  assign off    = addr[2:0];
  assign rd_hit = sel & re;
  assign wr_hit = sel & we;

  assign kbd_push = (keycode != 8'd0) && (keycode != kprev_q);
  assign kpop     = rd_hit && (off == IO_KDATA);
  assign kflush   = wr_hit && (off == IO_KDATA);

  mcpu_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (kflush),
    .push  (kbd_push),
    .pop   (kpop),
    .din   (keycode),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overflow sticky bit and frame counter next-state; a new overflow beats a clear.
  always_comb begin
    ovf_d   = ovf_q;
    frame_d = frame_q;
    if (wr_hit && (off == IO_KSTAT)) ovf_d = 1'b0;
    if (kbd_push && fifo_full && !kpop && !kflush) ovf_d = 1'b1;
    if (vsync_q && !vsync_q2) frame_d = frame_q + 16'd1;
    if (wr_hit && (off == IO_FRAME)) frame_d = wdata[15:0];
  end

  // Keyboard history, vsync synchroniser, overflow and frame registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      kprev_q  <= 8'd0;
      vsync_q  <= 1'b0;
      vsync_q2 <= 1'b0;
      ovf_q    <= 1'b0;
      frame_q  <= 16'd0;
    end else begin
      kprev_q  <= keycode;
      vsync_q  <= vsync;
      vsync_q2 <= vsync_q;
      ovf_q    <= ovf_d;
      frame_q  <= frame_d;
    end
  end

`ifdef MCPU_IO_TIMER_EN
  localparam int unsigned PW = $clog2(TIMER_PRESCALE + 1);

  logic [15:0]   timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          expired_q, expired_d;

  // Timer next-state: W1C clear first so a same-cycle expiry still sets; a load beats all.
  always_comb begin
    timer_d   = timer_q;
    presc_d   = presc_q;
    expired_d = expired_q;
    if (wr_hit && (off == IO_TSTAT) && wdata[0]) expired_d = 1'b0;
    if (timer_q != 16'd0) begin
      if (presc_q == PW'(TIMER_PRESCALE - 1)) begin
        presc_d = '0;
        timer_d = timer_q - 16'd1;
        if (timer_q == 16'd1) expired_d = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (wr_hit && (off == IO_TIMER)) begin
      timer_d   = wdata[15:0];
      presc_d   = '0;
      expired_d = 1'b0;
    end
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q   <= 16'd0;
      presc_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
    end
  end

  assign timer_exp = expired_q;
  assign timer_rd  = timer_q;
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{32'(TIMER_PRESCALE)};
  assign timer_exp = 1'b0;
  assign timer_rd  = 16'd0;
`endif

  logic unused_addr;
  assign unused_addr = ^{addr[13:3]};

  // Read mux: zero when not selected or at an unmapped offset.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        IO_KSTAT: rdata = DATA_WIDTH'(kstat_pack(~fifo_empty, fifo_full, ovf_q,
                                                 KSTAT_CNT_W'(fifo_count)));
        IO_KDATA: rdata = fifo_empty ? '0 : DATA_WIDTH'(fifo_dout);
        IO_FRAME: rdata = DATA_WIDTH'(frame_q);
        IO_TIMER: rdata = DATA_WIDTH'(timer_rd);
        IO_TSTAT: rdata = DATA_WIDTH'(timer_exp);
        default:  rdata = '0;
      endcase
    end
  end

  assign irq = ~fifo_empty | timer_exp;

endmodule

// File: tb/tb_mcpu_io_resp.sv
// Directed bench for mcpu_io_resp: reset values, keycode FIFO, frame counter
// and the timer (or its absence when MCPU_IO_TIMER_EN is undefined).
module tb_mcpu_io_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        re, we;
  logic [15:0] rdata;
  logic [7:0]  keycode;
  logic        vsync;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mcpu_io_resp #(
    .DATA_WIDTH     (16),
    .FIFO_DEPTH     (8),
    .TIMER_PRESCALE (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .re      (re),
    .we      (we),
    .rdata   (rdata),
    .keycode (keycode),
    .vsync   (vsync),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [15:0] d);
    addr  = 16'hC000 | {13'd0, off};
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = 16'h0000;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [15:0] d);
    addr = 16'hC000 | {13'd0, off};
    re   = 1'b1;
    #2;
    d = rdata;
    tick();
    re   = 1'b0;
    addr = 16'h0000;
  endtask

  // Look at a register without any bus strobe and without advancing time past an edge.
  task automatic peek(input logic [2:0] off, output logic [15:0] d);
    addr = 16'hC000 | {13'd0, off};
    re   = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    tick(); tick();
  endtask

  logic [15:0] d;
  logic [7:0]  drain_exp [8];

  initial begin
    reset = 1'b0; addr = 16'h0; wdata = 16'h0; re = 1'b0; we = 1'b0;
    keycode = 8'h00; vsync = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset state.
    for (int i = 0; i < 5; i++) begin
      bus_read(3'(i), d);
      check($sformatf("reset_off%0d", i), 32'(d), 32'h0);
    end
    check("reset_irq", 32'(irq), 32'h0);
    addr = 16'h1234; re = 1'b1; #1;
    check("unsel_rdata", 32'(rdata), 32'h0);
    re = 1'b0; addr = 16'h0;

    // Keycode repeat suppression.
    keycode = 8'h41; tick();
    keycode = 8'h41; tick();
    keycode = 8'h00; tick();
    keycode = 8'h41; tick();
    keycode = 8'h42; tick();
    keycode = 8'h00; tick();
    bus_read(3'd0, d); check("kstat_3", 32'(d), 32'h31);
    check("irq_fifo", 32'(irq), 32'h1);
    bus_read(3'd1, d); check("kdata_0", 32'(d), 32'h41);
    bus_read(3'd1, d); check("kdata_1", 32'(d), 32'h41);
    bus_read(3'd1, d); check("kdata_2", 32'(d), 32'h42);
    bus_read(3'd0, d); check("kstat_empty", 32'(d), 32'h0);
    bus_read(3'd1, d); check("kdata_empty", 32'(d), 32'h0);

    // Overflow with ten distinct codes.
    for (int i = 0; i < 10; i++) begin
      keycode = 8'h10 + 8'(i);
      tick();
    end
    keycode = 8'h00; tick();
    bus_read(3'd0, d); check("kstat_ovf", 32'(d), 32'h87);
    bus_write(3'd0, 16'h0000);
    bus_read(3'd0, d); check("kstat_ovf_clr", 32'(d), 32'h83);
    bus_read(3'd1, d); check("kdata_head", 32'(d), 32'h10);
    keycode = 8'h20; tick();
    keycode = 8'h00;
    bus_read(3'd0, d); check("kstat_refull", 32'(d), 32'h83);

    // Full FIFO: push and pop together.
    keycode = 8'h21;
    addr = 16'hFFF9; re = 1'b1;
    #2; d = rdata;
    check("kdata_pp", 32'(d), 32'h11);
    tick();
    re = 1'b0; addr = 16'h0; keycode = 8'h00;
    bus_read(3'd0, d); check("kstat_pp", 32'(d), 32'h83);
    drain_exp = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21};
    for (int i = 0; i < 8; i++) begin
      bus_read(3'd1, d);
      check($sformatf("drain_%0d", i), 32'(d), 32'(drain_exp[i]));
    end
    bus_read(3'd0, d); check("kstat_drained", 32'(d), 32'h0);

    // Flush, including flush beating a same-cycle push.
    keycode = 8'h55; tick();
    keycode = 8'h66; tick();
    keycode = 8'h00;
    bus_write(3'd1, 16'h0000);
    bus_read(3'd0, d); check("kstat_flush", 32'(d), 32'h0);
    keycode = 8'h77;
    bus_write(3'd1, 16'h0000);
    keycode = 8'h00; tick();
    bus_read(3'd0, d); check("kstat_flush_push", 32'(d), 32'h0);

    // Frame counter, with two-cycle latency check.
    vsync = 1'b1; tick();
    peek(3'd2, d); check("frame_lat1", 32'(d), 32'h0);
    tick();
    peek(3'd2, d); check("frame_lat2", 32'(d), 32'h1);
    vsync = 1'b0; tick(); tick();
    vsync_pulse();
    vsync_pulse();
    tick(); tick();
    bus_read(3'd2, d); check("frame_3", 32'(d), 32'h3);
    bus_write(3'd2, 16'hFFFF);
    bus_read(3'd2, d); check("frame_load", 32'(d), 32'hFFFF);
    vsync_pulse();
    tick(); tick();
    bus_read(3'd2, d); check("frame_wrap", 32'(d), 32'h0);

`ifdef MCPU_IO_TIMER_EN
    // Timer: N=2, prescale 4, expiry after 8 cycles.
    bus_write(3'd3, 16'd2);
    repeat (4) tick();
    peek(3'd3, d); check("timer_dec", 32'(d), 32'h1);
    repeat (3) tick();
    peek(3'd4, d); check("tstat_early", 32'(d), 32'h0);
    check("irq_early", 32'(irq), 32'h0);
    tick();
    peek(3'd4, d); check("tstat_exp", 32'(d), 32'h1);
    check("irq_timer", 32'(irq), 32'h1);
    peek(3'd3, d); check("timer_zero", 32'(d), 32'h0);
    bus_write(3'd4, 16'h0001);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_write(3'd3, 16'd0);
    repeat (12) tick();
    peek(3'd4, d); check("tstat_zero_wr", 32'(d), 32'h0);
`else
    // No timer: offsets 3/4 read 0 and irq never comes from a timer.
    bus_write(3'd3, 16'd2);
    peek(3'd3, d); check("notimer_rd", 32'(d), 32'h0);
    repeat (20) tick();
    check("notimer_irq", 32'(irq), 32'h0);
    peek(3'd4, d); check("notimer_tstat", 32'(d), 32'h0);
`endif

    // Reset mid-operation.
    bus_write(3'd2, 16'h0005);
    keycode = 8'h33; tick();
    keycode = 8'h00; tick();
    check("irq_pre_rst", 32'(irq), 32'h1);
    reset = 1'b0; tick();
    reset = 1'b1;
    bus_read(3'd0, d); check("rst_kstat", 32'(d), 32'h0);
    bus_read(3'd2, d); check("rst_frame", 32'(d), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
